// File: rtl/i2c_slave_mem.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : i2c_slave_mem
// Brief  : EEPROM-style I2C target with a byte memory and auto-incrementing
//          word pointer; open-drain sda, no clock stretching.
// Rev    : 1.0  initial release
// ============================================================================
module i2c_slave_mem #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  localparam int        PW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl,
  inout  wire           sda,
  output logic          busy,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [PW-1:0] ptr
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_ADDR      = 4'd1;
  localparam logic [3:0] S_ADDR_ACK  = 4'd2;
  localparam logic [3:0] S_WPTR      = 4'd3;
  localparam logic [3:0] S_WPTR_ACK  = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RDATA_ACK = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  logic [3:0]    r_state, w_state_nxt;
  logic          r_scl_s1, r_scl_s2, r_scl_d;
  logic          r_sda_s1, r_sda_s2, r_sda_d;
  logic          r_sda_oe, w_sda_oe_nxt;
  logic [2:0]    r_bitcnt, w_bitcnt_nxt;
  logic [6:0]    r_shift, w_shift_nxt;
  logic          r_phase, w_phase_nxt;
  logic          r_rw, w_rw_nxt;
  logic          w_busy_nxt, w_wr_pulse_nxt, w_mem_we;
  logic [PW-1:0] w_ptr_nxt, w_wr_addr_nxt, w_ptr_inc;
  logic [7:0]    w_wr_data_nxt, w_byte, w_rd;
  logic          w_scl_rise, w_scl_fall, w_start, w_stop, w_last, w_match;
  logic [7:0]    r_mem [DEPTH];

  assign sda = r_sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {scl, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {sda, r_sda_s1, r_sda_s2};
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_last     = w_scl_rise && (r_bitcnt == 3'd7);
  assign w_match    = (w_byte[7:1] == SLAVE_ADDR);
  assign w_rd       = r_mem[ptr];
  assign w_ptr_inc  = ptr + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = S_ADDR;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_ADDR:      if (w_last) w_state_nxt = w_match ? S_ADDR_ACK : S_WAIT_STOP;
        S_ADDR_ACK:  if (w_scl_fall && r_phase) w_state_nxt = r_rw ? S_RDATA : S_WPTR;
        S_WPTR:      if (w_last) w_state_nxt = S_WPTR_ACK;
        S_WPTR_ACK:  if (w_scl_fall && r_phase) w_state_nxt = S_WDATA;
        S_WDATA:     if (w_last) w_state_nxt = S_WDATA_ACK;
        S_WDATA_ACK: if (w_scl_fall && r_phase) w_state_nxt = S_WDATA;
        S_RDATA:     if (w_scl_fall && (r_bitcnt == 3'd0)) w_state_nxt = S_RDATA_ACK;
        S_RDATA_ACK: begin
          if (w_scl_rise && r_sda_s2)     w_state_nxt = S_WAIT_STOP;
          else if (w_scl_fall && r_phase) w_state_nxt = S_RDATA;
        end
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  // r_phase marks the second half of an ACK slot (ACK driven, or master ACK seen).
  always_comb begin
    w_sda_oe_nxt   = r_sda_oe;
    w_bitcnt_nxt   = r_bitcnt;
    w_shift_nxt    = r_shift;
    w_phase_nxt    = r_phase;
    w_rw_nxt       = r_rw;
    w_busy_nxt     = busy;
    w_ptr_nxt      = ptr;
    w_wr_pulse_nxt = 1'b0;
    w_wr_addr_nxt  = wr_addr;
    w_wr_data_nxt  = wr_data;
    w_mem_we       = 1'b0;
    if (w_start) begin
      w_bitcnt_nxt = 3'd0;
      w_shift_nxt  = 7'd0;
      w_sda_oe_nxt = 1'b0;
      w_phase_nxt  = 1'b0;
    end else if (w_stop) begin
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_phase_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR, S_WPTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte[6:0];
            w_bitcnt_nxt = r_bitcnt + 3'd1;
          end
          if (w_last) begin
            w_phase_nxt = 1'b0;
            if (r_state == S_ADDR) begin
              w_busy_nxt = w_match;
              w_rw_nxt   = w_byte[0];
            end else if (r_state == S_WPTR) begin
              w_ptr_nxt = w_byte[PW-1:0];
            end else begin
              w_mem_we       = 1'b1;
              w_wr_pulse_nxt = 1'b1;
              w_wr_addr_nxt  = ptr;
              w_wr_data_nxt  = w_byte;
              w_ptr_nxt      = w_ptr_inc;
            end
          end
        end
        S_ADDR_ACK, S_WPTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_phase_nxt  = ~r_phase;
            w_bitcnt_nxt = 3'd0;
            w_sda_oe_nxt = ~r_phase;
            if (r_phase && (r_state == S_ADDR_ACK) && r_rw) begin
              w_sda_oe_nxt = ~w_rd[7];
              w_bitcnt_nxt = 3'd1;
            end
          end
        end
        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_bitcnt == 3'd0) begin
              w_sda_oe_nxt = 1'b0;
              w_ptr_nxt    = w_ptr_inc;
              w_phase_nxt  = 1'b0;
            end else begin
              w_sda_oe_nxt = ~w_rd[3'd7 - r_bitcnt];
              w_bitcnt_nxt = r_bitcnt + 3'd1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_phase_nxt = ~r_sda_s2;
            if (r_sda_s2) w_busy_nxt = 1'b0;
          end else if (w_scl_fall && r_phase) begin
            w_sda_oe_nxt = ~w_rd[7];
            w_bitcnt_nxt = 3'd1;
            w_phase_nxt  = 1'b0;
          end
        end
        default: w_sda_oe_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sda_oe <= 1'b0;
      r_bitcnt <= 3'd0;
      r_shift  <= 7'd0;
      r_phase  <= 1'b0;
      r_rw     <= 1'b0;
      busy     <= 1'b0;
      ptr      <= '0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'h00;
    end else begin
      r_sda_oe <= w_sda_oe_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_phase  <= w_phase_nxt;
      r_rw     <= w_rw_nxt;
      busy     <= w_busy_nxt;
      ptr      <= w_ptr_nxt;
      wr_pulse <= w_wr_pulse_nxt;
      wr_addr  <= w_wr_addr_nxt;
      wr_data  <= w_wr_data_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
    end else if (w_mem_we) begin
      r_mem[ptr] <= w_byte;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_mem.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module : tb_i2c_slave_mem
// Brief  : Bit-banged I2C master with a byte-level memory model for i2c_slave_mem.
// Rev    : 1.0  initial release
// ============================================================================
module tb_i2c_slave_mem;

  localparam int T = 20;
  localparam int Q = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       m_oe = 1'b0;
  wire        sda;
  logic       busy, wr_pulse;
  logic [3:0] wr_addr, ptr;
  logic [7:0] wr_data;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  i2c_slave_mem #(.SLAVE_ADDR(7'h50), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .scl(scl_m), .sda(sda), .busy(busy),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .wr_data(wr_data), .ptr(ptr)
  );

  always #(T/2) clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] mdl_mem [16];
  int   mdl_ptr = 0;
  int   exp_q[$];
  int   seen_q[$];
  logic [7:0] rbuf[$];
  logic [7:0] wbuf[$];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Write-pulse scoreboard plus the "no drive change while scl high" invariant.
  logic prev_slv = 1'b0, prev_scl = 1'b1, prev_rst = 1'b0, prev_moe = 1'b0;
  always @(negedge clk) begin
    logic slv;
    int   e;
    slv = !m_oe && (sda === 1'b0);
    if (rst && prev_rst && scl_m && prev_scl && !m_oe && !prev_moe)
      chk("sda_hold_scl_high", slv, prev_slv);
    if (wr_pulse) begin
      seen_q.push_back((int'(wr_addr) << 8) | int'(wr_data));
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got addr %0d data 0x%0h, expected no pulse", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_pulse", (int'(wr_addr) << 8) | int'(wr_data), e);
      end
    end
    prev_slv = slv; prev_scl = scl_m; prev_rst = rst; prev_moe = m_oe;
  end

  task automatic bit_xfer(input bit b, output bit got);
    m_oe = !b; #Q; scl_m = 1'b1; #Q; got = (sda === 1'b1); #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    bit g;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], g);
    bit_xfer(1'b1, ack);
  endtask

  task automatic recv_byte(input bit nack, output logic [7:0] b);
    bit g;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, g); b[i] = g; end
    bit_xfer(nack, g);
  endtask

  task automatic bus_start();
    m_oe = 1'b1; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    m_oe = 1'b0; #Q; scl_m = 1'b1; #Q; m_oe = 1'b1; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; #Q; scl_m = 1'b1; #Q; m_oe = 1'b0; #Q; #(3*T);
  endtask

  task automatic write_txn(input logic [7:0] pbyte);
    bit ack;
    bus_start();
    send_byte(8'hA0, ack); chk("w_addr_ack", ack, 0);
    chk("w_busy", busy, 1);
    send_byte(pbyte, ack); chk("w_ptr_ack", ack, 0);
    mdl_ptr = pbyte % 16;
    foreach (wbuf[k]) begin
      exp_q.push_back((mdl_ptr << 8) | int'(wbuf[k]));
      mdl_mem[mdl_ptr] = wbuf[k];
      mdl_ptr = (mdl_ptr + 1) % 16;
      send_byte(wbuf[k], ack); chk("w_data_ack", ack, 0);
    end
    bus_stop();
    chk("w_busy_after_stop", busy, 0);
    chk("w_ptr_end", ptr, mdl_ptr);
    chk("w_missing_pulse", exp_q.size(), 0);
  endtask

  task automatic read_txn(input logic [7:0] pbyte, input int n);
    bit ack;
    logic [7:0] b;
    rbuf.delete();
    bus_start();
    send_byte(8'hA0, ack); chk("r_addr_ack", ack, 0);
    send_byte(pbyte, ack); chk("r_ptr_ack", ack, 0);
    mdl_ptr = pbyte % 16;
    bus_rstart();
    send_byte(8'hA1, ack); chk("r_addr2_ack", ack, 0);
    chk("r_busy", busy, 1);
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, b);
      rbuf.push_back(b);
      chk("r_data", b, mdl_mem[mdl_ptr]);
      mdl_ptr = (mdl_ptr + 1) % 16;
    end
    chk("r_sda_released", sda === 1'b1, 1);
    bus_stop();
    chk("r_busy_after_stop", busy, 0);
    chk("r_ptr_end", ptr, mdl_ptr);
  endtask

  task automatic miss_txn(input logic [6:0] a, input bit rw);
    bit ack;
    bus_start();
    send_byte({a, rw}, ack); chk("m_addr_nack", ack, 1);
    chk("m_busy", busy, 0);
    send_byte(8'hFF, ack); chk("m_data_nack", ack, 1);
    bus_stop();
    chk("m_busy_after_stop", busy, 0);
  endtask

  task automatic abort_txn();
    bit ack, g;
    logic [7:0] d;
    d = 8'h77;
    bus_start();
    send_byte(8'hA0, ack); chk("a_addr_ack", ack, 0);
    send_byte(8'h02, ack); chk("a_ptr_ack", ack, 0);
    exp_q.push_back((2 << 8) | 8'h77);
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], g);
    m_oe = 1'b0; #Q;
    chk("a_ack_driven", sda === 1'b0, 1);
    rst = 1'b0; #1;
    chk("a_sda_released", sda === 1'b1, 1);
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    mdl_ptr = 0;
    #(3*T);
    chk("a_busy", busy, 0);
    chk("a_ptr", ptr, 0);
    chk("a_missing_pulse", exp_q.size(), 0);
    scl_m = 1'b1; #(3*T);
    rst = 1'b1;
    @(posedge clk); #5; #Q;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, fails + 1);
  end

  initial begin
    int kind;
    for (int i = 0; i < 16; i++) mdl_mem[i] = 8'h00;
    repeat (10) @(posedge clk);
    #5;
    chk("rst_sda", sda === 1'b1, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ptr", ptr, 0);
    rst = 1'b1;
    @(posedge clk); #5; #Q;

    seen_q.delete();
    wbuf = '{8'h5A, 8'hC3};
    write_txn(8'h03);
    chk("dir_w_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("dir_w0", seen_q[0], 12'h35A);
      chk("dir_w1", seen_q[1], 12'h4C3);
    end
    chk("dir_w_ptr", ptr, 5);

    read_txn(8'h03, 2);
    chk("dir_r0", rbuf[0], 8'h5A);
    chk("dir_r1", rbuf[1], 8'hC3);
    chk("dir_r_ptr", ptr, 5);

    seen_q.delete();
    miss_txn(7'h51, 1'b0);
    chk("dir_m_no_pulse", seen_q.size(), 0);

    seen_q.delete();
    wbuf = '{8'h11, 8'h22};
    write_txn(8'h1F);
    chk("dir_wrap_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      chk("dir_wrap0", seen_q[0], 12'hF11);
      chk("dir_wrap1", seen_q[1], 12'h022);
    end
    chk("dir_wrap_ptr", ptr, 1);

    abort_txn();
    read_txn(8'h0F, 2);
    chk("dir_abort_r0", rbuf[0], 8'h00);
    wbuf = '{8'hE7};
    write_txn(8'h08);
    read_txn(8'h08, 1);
    chk("dir_abort_r1", rbuf[0], 8'hE7);

    for (int it = 0; it < 20; it++) begin
      kind = $urandom_range(0, 4);
      if (kind <= 1) begin
        wbuf.delete();
        repeat ($urandom_range(1, 4)) wbuf.push_back(8'($urandom_range(0, 255)));
        write_txn(8'($urandom_range(0, 255)));
      end else if (kind <= 3) begin
        read_txn(8'($urandom_range(0, 255)), $urandom_range(1, 4));
      end else begin
        logic [6:0] a;
        a = 7'($urandom_range(0, 127));
        if (a == 7'h50) a = 7'h51;
        miss_txn(a, 1'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_slave_mem.md
Name: i2c_slave_mem

Overview:
- I2C slave target with an internal byte memory, bus-compatible with the team's I2C master.
- Sits directly downstream of the master on the shared sda/scl bus.
- Drives the address/data ACK that the master samples, stores written bytes and returns read bytes.
- EEPROM-style protocol: the first byte of a write sets the word pointer; later bytes are data; the pointer auto-increments.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit bus address this target answers to.
- DEPTH, 16, memory depth in bytes (power of 2, ≤256); pointer width PW = $clog2(DEPTH).

Ports:
- clk  input  1  system clock (50 MHz nominal; must be ≥ 8× scl frequency).
- rst  input  1  asynchronous, active-low reset.
- scl  input  1  I2C clock from master (no clock stretching).
- sda  inout  1  I2C data; the slave only drives 0 or releases to z (open-drain).
- busy  output  1  high from an address-matched START until STOP/NACK-idle.
- wr_pulse  output  1  one clk pulse when a data byte is written to memory.
- wr_addr  output  PW  memory index of the current wr_pulse.
- wr_data  output  8  byte written on the current wr_pulse.
- ptr  output  PW  current word pointer.

Behaviour:
- Reset state (rst low):
  - sda released (z), busy=0, wr_pulse=0, wr_addr=0, wr_data=0, ptr=0, memory cleared to 8'h00, state=IDLE.
  - Reset asserted mid-transfer releases sda immediately.
- Input sampling:
  - scl and sda each pass through a 2-flop synchronizer, then a third register for edge detect.
  - All decisions use the synchronized values.
  - scl_rise and scl_fall are single-cycle strobes.
- Bus conditions (checked every cycle, any state):
  - START = sync sda falls while sync scl=1.
  - STOP = sync sda rises while sync scl=1.
  - START (including repeated START) → clear bit counter and shift register, go to ADDR.
  - STOP → release sda, go to IDLE, busy=0.
  - START/STOP take priority over data handling in the same cycle.
- Bit timing:
  - Receive: shift in sda on scl_rise, MSB first.
  - Transmit: sda changes only on scl_fall.
  - bitcnt is 0..7, 3 bits wide, wraps to 0 after the 8th bit.
- States:
  - IDLE: sda released; wait for START.
  - ADDR: receive 8 bits {addr[6:0], rw}.
    - At the 8th scl_rise, if addr matches SLAVE_ADDR → set busy, go to ADDR_ACK.
    - Otherwise → WAIT_STOP, and sda is never driven.
  - ADDR_ACK:
    - At the next scl_fall drive sda=0.
    - At the following scl_fall: if rw=0, release sda and go to WPTR.
    - If rw=1, drive bit7 of mem[ptr] instead and go to RDATA with bitcnt=1.
  - WPTR: receive 8 bits; ptr ← byte[PW-1:0] (upper bits ignored); → WPTR_ACK.
  - WPTR_ACK: drive 0 for one scl low-high-low period, same timing as ADDR_ACK; → WDATA.
  - WDATA: receive 8 bits.
    - At the 8th scl_rise: mem[ptr] ← byte; wr_pulse=1 for one clk with wr_addr=ptr, wr_data=byte.
    - Then ptr ← ptr+1, wrapping DEPTH-1 → 0; → WDATA_ACK.
  - WDATA_ACK: ACK as above; → WDATA (unlimited bytes until STOP).
  - RDATA:
    - On each scl_fall output the next bit of mem[ptr]: bit=0 drives 0, bit=1 releases.
    - After bit0 has been presented and its scl_fall occurs: release sda, ptr ← ptr+1 (wrap), → RDATA_ACK.
  - RDATA_ACK: sample master ACK on scl_rise.
    - sda=0 → at the next scl_fall drive bit7 of the new mem[ptr], → RDATA.
    - sda=1 (NACK) → WAIT_STOP.
  - WAIT_STOP: sda released; wait for STOP or START.
- Invariants:
  - The slave never drives sda=1.
  - The slave never drives sda while scl is high, except to hold a bit it is already driving.
  - The memory read port is combinational, indexed by ptr.

Test Plan:
- Reset: hold rst=0 for 10 clk with the bus idle → sda=z, busy=0, ptr=0, all outputs 0.
- Write: START, 0xA0 (addr 0x50, W), ptr 0x03, data 0x5A, 0xC3, STOP.
  - ACK=0 on all 4 ACK slots.
  - wr_pulse twice: (3,0x5A), then (4,0xC3).
  - ptr=5; busy falls at STOP.
- Read: START, 0xA0, ptr 0x03, repeated START, 0xA1, master ACKs byte 1 and NACKs byte 2, STOP.
  - Slave returns 0x5A then 0xC3; ptr=5; sda released after the NACK.
- Address mismatch: START, 0xA2 (addr 0x51), data 0xFF, STOP.
  - sda never driven low by the slave (the master sees NACK); no wr_pulse; busy stays 0.
- Pointer wrap: write ptr 0x0F with DEPTH=16, data 0x11, 0x22.
  - Writes land at 15 then 0; ptr=1.
  - Pointer byte 0x1F is truncated to 0xF.
- Abort: rst pulsed low mid-WDATA while the slave is driving ACK → sda released within the same clk; state IDLE; following transaction succeeds.
